// File: rtl/phase_sequencer_pkg.sv
// Shared types and helpers for the phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phase_sequencer_pkg;

  // Top-level sequencer states.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Ceiling log2, clamped to at least 1 so a 2-phase ring still has an index bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/phase_sequencer_dwell_counter.sv
// Per-phase dwell counter: counts extra cycles in the current phase up to limit.
// Latency: done is combinational from the registered count and limit.
// Backpressure: hold freezes the count; clr wins over hold.
module phase_dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               hold,
  input  logic [DWELL_W-1:0] limit,
  output logic               done
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // The phase may advance once the count has reached its dwell limit.
  assign done = (cnt_q == limit);

  // Next count: clear on phase entry, otherwise climb to the limit unless held.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold && (cnt_q < limit)) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase ring with per-phase dwell, hold, boundary halt/resume, restart, retired count.
// Latency: restart/resume/advance take effect at the next edge; phase_last is combinational.
// Backpressure: hold freezes phase and dwell in RUN; ignored while halted.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int                              NUM_PHASES  = 3,
  parameter int                              DWELL_W     = 4,
  parameter logic [NUM_PHASES*DWELL_W-1:0]   PHASE_DWELL = '0,
  parameter int                              CNT_W       = 16,
  localparam int                             IDX_W       = clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  halt_req,
  input  logic                  resume,
  input  logic                  restart,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  phase_first,
  output logic                  phase_last,
  output logic                  halted,
  output logic [CNT_W-1:0]      retired
);

  localparam logic [NUM_PHASES-1:0] PHASE0 = NUM_PHASES'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_PHASES - 1);

  state_e                  state_q, state_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q, first_d;
  logic [CNT_W-1:0]        retired_q, retired_d;
  logic [DWELL_W-1:0]      dwell_limit;
  logic                    dwell_done;
  logic                    dwell_clr;
  logic                    in_run;

  assign in_run = (state_q == ST_RUN);

  // Select the dwell field belonging to the active phase index.
  always_comb begin
    dwell_limit = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (idx_q == IDX_W'(i)) dwell_limit = PHASE_DWELL[i*DWELL_W +: DWELL_W];
    end
  end

  // Halted behaves like a permanent hold so the count stays frozen.
  phase_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (dwell_clr),
    .hold  (hold || !in_run),
    .limit (dwell_limit),
    .done  (dwell_done)
  );

  assign phase_last = in_run && !hold && dwell_done;

  // Next-state: restart beats halt entry, which beats hold/advance.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    first_d   = 1'b0;
    retired_d = retired_q;
    dwell_clr = 1'b0;
    if (restart || (!in_run && resume)) begin
      state_d   = ST_RUN;
      phase_d   = PHASE0;
      idx_d     = '0;
      first_d   = 1'b1;
      dwell_clr = 1'b1;
    end else if (phase_last) begin
      dwell_clr = 1'b1;
      if (phase_q[NUM_PHASES-1]) retired_d = retired_q + CNT_W'(1);
      if (phase_q[NUM_PHASES-1] && halt_req) begin
        state_d = ST_HALTED;
        phase_d = '0;
        idx_d   = '0;
      end else begin
        phase_d = {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        first_d = 1'b1;
      end
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      phase_q   <= PHASE0;
      idx_q     <= '0;
      first_q   <= 1'b1;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      retired_q <= retired_d;
    end
  end

  assign phase       = phase_q;
  assign phase_idx   = idx_q;
  assign phase_first = first_q;
  assign halted      = (state_q == ST_HALTED);
  assign retired     = retired_q;

endmodule
